// File: rtl/id_stage_pkg.sv
// Shared MIPS definitions used by fetch, decode and control: opcodes, funct codes,
// the instruction field layout and small decode helpers.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) return {16'h0000, imm};
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic uses_rs(input logic [5:0] op, input logic [5:0] funct);
    if (op == OP_J || op == OP_JAL || op == OP_LUI) return 1'b0;
    if (op == OP_RTYPE && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/decode boundary: instruction in, decoded fields and stall feedback out.
interface id_stage_if;
  logic [31:0] ins;
  logic [31:0] pc_in;
  logic        flush;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        stall_f;
  logic [15:0] stall_cnt;

  modport master (
    output ins, pc_in, flush,
    input  op, rs, rt, rd, shamt, funct, imm_ext, pc_out, valid_out, stall_f, stall_cnt
  );

  modport slave (
    input  ins, pc_in, flush,
    output op, rs, rt, rd, shamt, funct, imm_ext, pc_out, valid_out, stall_f, stall_cnt
  );
endinterface

// File: rtl/id_stage_load_use_detect.sv
// Load-use hazard check: the instruction in ID reads the register a load issued
// last cycle is still writing.
module load_use_detect
  import id_stage_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  input  logic       v_r,
  input  logic       ld_pend,
  input  logic [4:0] ld_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = uses_rs(op, funct) && (rs == ld_rt);
    rt_hit = uses_rt(op) && (rt == ld_rt);
    // $0 is never really written, so a load to it cannot create a dependency.
    hazard = v_r && ld_pend && (ld_rt != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, field/immediate decode, load-use
// bubble insertion and a saturating bubble counter.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   bus
);

  instr_t      ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        v_q, v_d;
  logic        ld_pend_q, ld_pend_d;
  logic [4:0]  ld_rt_q, ld_rt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hazard;
  logic        issue;
  logic        stall;

  load_use_detect u_load_use_detect (
    .op      (ir_q.op),
    .rs      (ir_q.rs),
    .rt      (ir_q.rt),
    .funct   (ir_q.funct),
    .v_r     (v_q),
    .ld_pend (ld_pend_q),
    .ld_rt   (ld_rt_q),
    .hazard  (hazard)
  );

  always_comb begin
    issue       = v_q && !hazard;
    stall       = hazard && !bus.flush;
    ir_d        = ir_q;
    pc_d        = pc_q;
    v_d         = v_q;
    ld_pend_d   = issue && (ir_q.op == OP_LW);
    ld_rt_d     = ir_q.rt;
    stall_cnt_d = stall_cnt_q;

    if (bus.flush) begin
      ir_d = '0;
      v_d  = 1'b0;
    end else if (!stall) begin
      ir_d = instr_t'(bus.ins);
      pc_d = bus.pc_in;
      v_d  = 1'b1;
    end

    if (stall && stall_cnt_q != STALL_CNT_MAX) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q        <= '0;
      pc_q        <= '0;
      v_q         <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_rt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      v_q         <= v_d;
      ld_pend_q   <= ld_pend_d;
      ld_rt_q     <= ld_rt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.op        = ir_q.op;
  assign bus.rs        = ir_q.rs;
  assign bus.rt        = ir_q.rt;
  assign bus.rd        = ir_q.rd;
  assign bus.shamt     = ir_q.shamt;
  assign bus.funct     = ir_q.funct;
  assign bus.imm_ext   = ext_imm(ir_q.op, {ir_q.rd, ir_q.shamt, ir_q.funct});
  assign bus.pc_out    = pc_q;
  assign bus.valid_out = issue;
  assign bus.stall_f   = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: ins  in  32  instruction word from fetch unit.
REQ-004 SHALL have ports: pc_in  in  32  fetch nextpc (PC+4) paired with ins.
REQ-005 SHALL have ports: flush  in  1  taken branch/jump/jr resolved; kill ID contents.
REQ-006 SHALL have ports: op/rs/rt/rd/shamt/funct  out  6/5/5/5/5/6  fields of latched word.
REQ-007 SHALL have ports: imm_ext  out  32  extended imme; pc_out  out  32  latched pc_in.
REQ-008 SHALL have ports: valid_out  out  1  issued instruction is real (0 = bubble).
REQ-009 SHALL have ports: stall_f  out  1  fetch must hold PC and ins this cycle.
REQ-010 SHALL have ports: stall_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-011 SHALL hold an IF/ID register {ir, pc_r, v_r}; fields and imm_ext combinational from ir.
REQ-012 Per edge, priority: reset > flush (ir<=0, v_r<=0) > stall_f (hold) > load (ir<=ins, pc_r<=pc_in, v_r<=1).
REQ-013 imm_ext SHALL zero-extend ir[15:0] for op 0x0C/0x0D/0x0E (andi/ori/xori), sign-extend otherwise.
REQ-014 uses_rs SHALL be 1 except op 0x02/0x03/0x0F and R-type funct 0x00/0x02/0x03 (sll/srl/sra).
REQ-015 uses_rt SHALL be 1 for op 0x00, 0x04, 0x05, 0x2B; 0 otherwise.
REQ-016 SHALL register ld_pend<=issue&&(op==0x23) and ld_rt<=rt every edge (issue = valid_out).
REQ-017 hazard = v_r && ld_pend && ld_rt!=0 && ((uses_rs&&rs==ld_rt)||(uses_rt&&rt==ld_rt)).
REQ-018 valid_out SHALL be v_r && !hazard; stall_f SHALL be hazard && !flush.
REQ-019 A load-use hazard SHALL produce exactly one bubble: ld_pend clears after the bubble, instruction issues next cycle.
REQ-020 flush coincident with hazard: flush wins, IF/ID cleared, stall_f=0, no stall_cnt increment.
REQ-021 stall_cnt SHALL increment on each cycle stall_f=1 and saturate at 0xFFFF.
REQ-022 Latency: ins presented at edge N appears on outputs after edge N (one cycle), valid_out same cycle unless hazard.

Reset
REQ-023 On reset: ir=0x00000000, pc_r=0, v_r=0, ld_pend=0, ld_rt=0, stall_cnt=0; thus valid_out=0, stall_f=0, imm_ext=0.
REQ-024 Reset asserted mid-stall SHALL clear the stall on the same edge; no residual bubble afterwards.

Structure
REQ-025 Opcode/funct constants (LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, LUI 0x0F, ANDI/ORI/XORI, SLL/SRL/SRA) SHALL live in the shared MIPS definitions package used by fetch and control.
REQ-026 Hazard detection SHALL be one sub-module, load_use_detect (combinational, inputs ir fields, v_r, ld_pend, ld_rt; output hazard).

Verification
REQ-027 reset held 2 cycles then released, ins=0x2004FFFF -> after reset all outputs 0; next edge valid_out=1, rt=4, imm_ext=0xFFFFFFFF.
REQ-028 ins=0x3404FFFF (ori $4,$0,0xFFFF) -> imm_ext=0x0000FFFF, op=0x0D, valid_out=1.
REQ-029 ins=0x8D280000 then 0x010B5020 (lw $8; add $10,$8,$11) -> one cycle stall_f=1, valid_out=0, stall_cnt=1; next cycle add issues with rd=10, funct=0x20.
REQ-030 ins=0x8D200000 then 0x00005020 (lw $0; add using $0) -> no stall, stall_f stays 0, stall_cnt=0.
REQ-031 load-use hazard cycle with flush=1 -> stall_f=0, next cycle valid_out=0, ir=0, stall_cnt unchanged.
REQ-032 force 0xFFFF+2 hazard cycles -> stall_cnt saturates at 0xFFFF.
